// File: rtl/bsel_pkg.sv
// Shared types for the bit-select unit: controller state encoding and the
// count/index op-codes understood by the cix counting block.
package bsel_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bsel_state_t;

    typedef enum logic [1:0] {
        CIX_PCNT = 2'd0,
        CIX_ZCNT = 2'd1,
        CIX_CTZ  = 2'd2,
        CIX_CLZ  = 2'd3
    } cix_op_t;

endpackage

// File: rtl/bsel_cix.sv
// Combinational count/index block: population count, zero count and
// trailing/leading zero count of a 2**ORDER-bit word.
module cix
    import bsel_pkg::*;
#(
    parameter int ORDER = 3
) (
    input  cix_op_t                 op,
    input  logic [(2**ORDER)-1:0]   data,
    output logic [ORDER:0]          cnt
);

    localparam int W = 2**ORDER;

    logic seen;

    always_comb begin
        cnt  = '0;
        seen = 1'b0;
        case (op)
            CIX_PCNT: begin
                for (int i = 0; i < W; i++) begin
                    cnt = cnt + (ORDER+1)'(data[i]);
                end
            end
            CIX_ZCNT: begin
                for (int i = 0; i < W; i++) begin
                    cnt = cnt + (ORDER+1)'(!data[i]);
                end
            end
            CIX_CTZ: begin
                // An all-zero word yields W.
                for (int i = 0; i < W; i++) begin
                    if (!seen) begin
                        if (data[i]) seen = 1'b1;
                        else         cnt  = cnt + (ORDER+1)'(1);
                    end
                end
            end
            CIX_CLZ: begin
                for (int i = W-1; i >= 0; i--) begin
                    if (!seen) begin
                        if (data[i]) seen = 1'b1;
                        else         cnt  = cnt + (ORDER+1)'(1);
                    end
                end
            end
            default: cnt = '0;
        endcase
    end

endmodule

// File: rtl/bsel.sv
// Sequential bit-select: finds the index of the k-th set (or clear) bit of a
// word by binary descent, one halving of the search window per clock.
module bsel
    import bsel_pkg::*;
#(
    parameter int ORDER = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_inv,
    input  logic [(2**ORDER)-1:0]   in_data,
    input  logic [ORDER-1:0]        in_rank,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ORDER-1:0]        out_pos,
    output logic                    out_none
);

    localparam int W = 2**ORDER;
    localparam logic [ORDER-1:0] LAST_STEP = ORDER'(ORDER - 1);

    bsel_state_t        state;
    logic [W-1:0]       d;
    logic [ORDER:0]     k;
    logic [ORDER-1:0]   pos;
    logic [ORDER-1:0]   step;

    logic [W-1:0]       win;
    logic [ORDER:0]     c;
    logic [ORDER-1:0]   h;
    logic               none_w;

    // Lower half of the current search window: h = W >> (s+1) ones from bit 0.
    function automatic logic [W-1:0] low_mask(input logic [ORDER-1:0] s);
        logic [W-1:0] m;
        m = '0;
        for (int i = 0; i < W; i++) begin
            if (i < (W >> (int'(s) + 1))) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [ORDER-1:0] half_w(input logic [ORDER-1:0] s);
        return ORDER'(W >> (int'(s) + 1));
    endfunction

    assign win = d & low_mask(step);
    assign h   = half_w(step);

    // Inversion is folded into d at capture, so a plain popcount serves both modes.
    cix #(
        .ORDER (ORDER)
    ) u_cix (
        .op   (CIX_PCNT),
        .data (win),
        .cnt  (c)
    );

    // After the last step the target, if it exists, has been shifted down to bit 0.
    assign none_w   = !(d[0] && (k == '0));
    assign in_ready = (state == IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            d         <= '0;
            k         <= '0;
            pos       <= '0;
            step      <= '0;
            out_valid <= 1'b0;
            out_pos   <= '0;
            out_none  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        d     <= in_data ^ {W{in_inv}};
                        k     <= {1'b0, in_rank};
                        pos   <= '0;
                        step  <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Target lies in the upper half: skip the lower half's count.
                    if (k >= c) begin
                        k   <= k - c;
                        pos <= pos + h;
                        d   <= d >> h;
                    end
                    step <= step + ORDER'(1);
                    if (step == LAST_STEP) state <= DONE;
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_none  <= none_w;
                        out_pos   <= none_w ? '0 : pos;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bsel.sv
// Directed and randomised checks of the bit-select unit, including
// backpressure, mid-operation reset and back-to-back streaming.
module tb_bsel;

    localparam int NRAND = 5000;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    logic       reset;
    logic       in_valid, in_ready, in_inv;
    logic [7:0] in_data;
    logic [2:0] in_rank;
    logic       out_valid, out_ready, out_none;
    logic [2:0] out_pos;

    bsel #(.ORDER(3)) u_dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inv    (in_inv),
        .in_data   (in_data),
        .in_rank   (in_rank),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pos   (out_pos),
        .out_none  (out_none)
    );

    // One independent unit per order, checked against a linear-scan model.
    for (genvar g = 0; g < 4; g++) begin : g_rand
        localparam int O  = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 5;
        localparam int RW = 2**O;

        logic          r_reset, r_in_valid, r_in_ready, r_in_inv;
        logic          r_out_valid, r_out_ready, r_out_none;
        logic [RW-1:0] r_in_data;
        logic [O-1:0]  r_in_rank, r_out_pos;
        logic          fin = 1'b0;

        bsel #(.ORDER(O)) u_rdut (
            .clock     (clock),
            .reset     (r_reset),
            .in_valid  (r_in_valid),
            .in_ready  (r_in_ready),
            .in_inv    (r_in_inv),
            .in_data   (r_in_data),
            .in_rank   (r_in_rank),
            .out_valid (r_out_valid),
            .out_ready (r_out_ready),
            .out_pos   (r_out_pos),
            .out_none  (r_out_none)
        );

        initial begin
            logic [RW-1:0] dv, de;
            logic [O-1:0]  kv;
            logic          iv, enone;
            int            cnt, epos, nw;
            r_reset = 1'b1; r_in_valid = 1'b0; r_out_ready = 1'b1;
            r_in_inv = 1'b0; r_in_data = '0; r_in_rank = '0;
            repeat (2) @(posedge clock);
            #1 r_reset = 1'b0;
            for (int v = 0; v < NRAND; v++) begin
                dv = RW'($urandom);
                if (v % 16 == 0) dv = '0;
                if (v % 16 == 1) dv = '1;
                kv = O'($urandom);
                iv = 1'($urandom);
                de = dv ^ {RW{iv}};
                cnt = 0; enone = 1'b1; epos = 0;
                for (int i = 0; i < RW; i++) begin
                    if (de[i]) begin
                        if (enone && cnt == int'(kv)) begin
                            enone = 1'b0;
                            epos  = i;
                        end
                        cnt++;
                    end
                end
                r_in_valid = 1'b1; r_in_inv = iv; r_in_data = dv; r_in_rank = kv;
                nw = 0;
                while (!r_in_ready && nw < 20) begin @(posedge clock); #1; nw++; end
                @(posedge clock); #1;
                r_in_valid = 1'b0;
                nw = 0;
                while (!r_out_valid && nw < 20) begin @(posedge clock); #1; nw++; end
                if (!r_out_valid) begin
                    check($sformatf("rand%0d_timeout", O), 32'd0, 32'd1);
                    break;
                end
                check($sformatf("rand%0d_d%0h_k%0d_i%0d", O, dv, kv, iv),
                      32'(r_out_pos) | (32'(r_out_none) << 16),
                      32'(epos) | (32'(enone) << 16));
                @(posedge clock); #1;
            end
            fin = 1'b1;
        end
    end

    task automatic run_one(input string tag, input logic inv, input logic [7:0] data,
                           input logic [2:0] rank, input int exp_pos, input logic exp_none);
        int lat;
        int nw;
        in_valid = 1'b1; in_inv = inv; in_data = data; in_rank = rank;
        nw = 0;
        while (!in_ready && nw < 20) begin @(posedge clock); #1; nw++; end
        @(posedge clock); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clock); #1; lat++; end
        check({tag, "_lat"},  32'(lat),      32'd4);
        check({tag, "_pos"},  32'(out_pos),  32'(exp_pos));
        check({tag, "_none"}, 32'(out_none), 32'(exp_none));
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        check({tag, "_rdy"},  32'(in_ready), 32'd1);
    endtask

    initial begin
        int nw, cyc, nres, idx, extra;
        logic seen, acc, hs;
        logic [2:0] p;
        int res [4];
        int hcyc [4];
        int exp_b2b [4] = '{2, 4, 5, 7};

        reset = 1'b1; in_valid = 1'b0; in_inv = 1'b0; in_data = '0; in_rank = '0; out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_pos",   32'(out_pos),   32'd0);
        check("rst_out_none",  32'(out_none),  32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        run_one("b4_k0",  1'b0, 8'hB4, 3'd0, 2, 1'b0);
        run_one("b4_k2",  1'b0, 8'hB4, 3'd2, 5, 1'b0);
        run_one("b4_k3",  1'b0, 8'hB4, 3'd3, 7, 1'b0);
        run_one("b4_k4",  1'b0, 8'hB4, 3'd4, 0, 1'b1);
        run_one("zb4_k2", 1'b1, 8'hB4, 3'd2, 3, 1'b0);
        run_one("zff_k0", 1'b1, 8'hFF, 3'd0, 0, 1'b1);
        run_one("z00_k7", 1'b1, 8'h00, 3'd7, 7, 1'b0);

        // Backpressure with a competing request held on the input.
        in_valid = 1'b1; in_inv = 1'b0; in_data = 8'hB4; in_rank = 3'd0;
        @(posedge clock); #1;
        in_valid = 1'b0;
        nw = 0;
        while (!out_valid && nw < 20) begin @(posedge clock); #1; nw++; end
        in_valid = 1'b1; in_data = 8'hFF; in_rank = 3'd5;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            check($sformatf("bp_vld%0d", i),  32'(out_valid), 32'd1);
            check($sformatf("bp_pos%0d", i),  32'(out_pos),   32'd2);
            check($sformatf("bp_none%0d", i), 32'(out_none),  32'd0);
            check($sformatf("bp_rdy%0d", i),  32'(in_ready),  32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        check("bp_after_rdy", 32'(in_ready),  32'd1);
        check("bp_after_vld", 32'(out_valid), 32'd0);

        // Reset during the second descent step drops the request.
        in_valid = 1'b1; in_data = 8'hB4; in_rank = 3'd2;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("mid_rst_rdy", 32'(in_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock); #1;
            seen = seen | out_valid;
        end
        check("mid_rst_no_out", 32'(seen), 32'd0);
        run_one("post_rst", 1'b0, 8'hB4, 3'd3, 7, 1'b0);

        // Streaming: accept, ORDER steps, result edge, handshake edge, idle cycle.
        in_inv = 1'b0; in_data = 8'hB4; in_rank = 3'd0; idx = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        nres = 0; cyc = 0;
        while (nres < 4 && cyc < 100) begin
            acc = in_valid && in_ready;
            hs  = out_valid && out_ready;
            p   = out_pos;
            @(posedge clock); #1;
            cyc++;
            if (acc) begin
                idx++;
                if (idx < 4) in_rank = 3'(idx);
                else         in_valid = 1'b0;
            end
            if (hs) begin
                res[nres]  = int'(p);
                hcyc[nres] = cyc;
                nres++;
            end
        end
        check("b2b_count", 32'(nres), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("b2b_pos%0d", i), 32'(res[i]), 32'(exp_b2b[i]));
            if (i > 0) check($sformatf("b2b_gap%0d", i), 32'(hcyc[i] - hcyc[i-1]), 32'd6);
        end
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid && out_ready) extra++;
            @(posedge clock); #1;
        end
        check("b2b_no_dup", 32'(extra), 32'd0);
        in_valid = 1'b0; out_ready = 1'b0;

        nw = 0;
        while (!(g_rand[0].fin && g_rand[1].fin && g_rand[2].fin && g_rand[3].fin) && nw < 60000) begin
            @(posedge clock);
            nw++;
        end
        check("rand_all_done",
              32'(g_rand[0].fin && g_rand[1].fin && g_rand[2].fin && g_rand[3].fin), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
